// File: rtl/lz77_stream_compressor_if.sv
// rtl/lz77_stream_compressor_if.sv - byte-in / packed-word-out stream bundle for the LZ77 compressor
interface lz77_stream_compressor_if #(
    parameter int OUT_WIDTH = 8
);
    logic [7:0]           s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/lz77_stream_compressor.sv
// rtl/lz77_stream_compressor.sv - LZ77 byte-stream compressor, one byte compare per cycle, bit-packed token output
module lz77_stream_compressor #(
    parameter int OFFSET_BITS  = 12,
    parameter int LENGTH_BITS  = 6,
    parameter int MIN_MATCH    = 3,
    parameter int SEARCH_DEPTH = 256,
    parameter int OUT_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] bytes_in,
    output logic [31:0] tokens_out,
    lz77_stream_compressor_if.slave io
);
    localparam int HIST_DEPTH = (1 << OFFSET_BITS) - 1;
    localparam int LA_DEPTH   = (1 << LENGTH_BITS) - 1;
    localparam int LIT_W      = 9;
    localparam int MATCH_W    = 1 + OFFSET_BITS + LENGTH_BITS;
    localparam int TOK_W      = (MATCH_W > LIT_W) ? MATCH_W : LIT_W;
    localparam int ACC_W      = OUT_WIDTH + TOK_W - 1;
    localparam int CNT_W      = $clog2(ACC_W + 1);
    localparam int MAX_D      = (SEARCH_DEPTH < HIST_DEPTH) ? SEARCH_DEPTH : HIST_DEPTH;

    localparam logic [OFFSET_BITS-1:0] HIST_C    = OFFSET_BITS'(HIST_DEPTH);
    localparam logic [OFFSET_BITS-1:0] HIST_LAST = OFFSET_BITS'(HIST_DEPTH - 1);
    localparam logic [OFFSET_BITS-1:0] MAXD_C    = OFFSET_BITS'(MAX_D);
    localparam logic [LENGTH_BITS-1:0] LA_C      = LENGTH_BITS'(LA_DEPTH);
    localparam logic [LENGTH_BITS-1:0] MINM_C    = LENGTH_BITS'(MIN_MATCH);
    localparam logic [CNT_W-1:0]       OW_C      = CNT_W'(OUT_WIDTH);
    localparam logic [CNT_W-1:0]       ACCW_C    = CNT_W'(ACC_W);

    typedef enum logic [2:0] {IDLE, FILL, SEARCH, EMIT, COMMIT, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]             hist [0:HIST_DEPTH-1];
    logic [7:0]             la   [0:LA_DEPTH-1];
    logic [OFFSET_BITS-1:0] wr_ptr, hist_count, d, best_dist, max_d, diff, hidx;
    logic [LENGTH_BITS-1:0] la_count, k, k_inc, best_len, commit_left, cand_len, consume;
    logic                   last_seen, tail;
    logic [7:0]             src;
    logic                   eq, cand_end, accept, can_take, use_match, pop;
    logic [TOK_W-1:0]       tok;
    logic [CNT_W-1:0]       tok_len, acc_cnt, cnt_pop, cnt_nxt;
    logic [ACC_W-1:0]       acc, acc_pop, acc_nxt, tok_top;

    // Source byte: history when the candidate reaches back before the lookahead, else overlap into lookahead.
    always_comb begin
        max_d    = (hist_count < MAXD_C) ? hist_count : MAXD_C;
        diff     = d - OFFSET_BITS'(k);
        hidx     = (wr_ptr >= diff) ? (wr_ptr - diff) : (wr_ptr + HIST_C - diff);
        src      = (32'(k) < 32'(d)) ? hist[hidx] : la[k - LENGTH_BITS'(d)];
        k_inc    = k + 1'b1;
        eq       = (la[k] == src);
        cand_end = !eq || (k_inc == la_count);
        cand_len = eq ? k_inc : k;
    end

    always_comb begin
        use_match = (best_len >= MINM_C);
        if (use_match) begin
            tok     = TOK_W'({1'b0, best_dist, best_len});
            tok_len = CNT_W'(MATCH_W);
            consume = best_len;
        end else begin
            tok     = TOK_W'({1'b1, la[0]});
            tok_len = CNT_W'(LIT_W);
            consume = LENGTH_BITS'(1);
        end
        tok_top = ACC_W'(tok) << (ACCW_C - tok_len);
    end

    // Accumulator is MSB-aligned; a token is only accepted while no complete word is waiting.
    always_comb begin
        io.m_valid = (acc_cnt >= OW_C) || (tail && acc_cnt != '0);
        io.m_last  = tail && (acc_cnt != '0) && (acc_cnt <= OW_C);
        io.m_data  = acc[ACC_W-1 -: OUT_WIDTH];
        pop        = io.m_valid && io.m_ready;
        can_take   = (acc_cnt < OW_C);
        cnt_pop    = acc_cnt;
        acc_pop    = acc;
        if (pop) begin
            cnt_pop = (acc_cnt >= OW_C) ? (acc_cnt - OW_C) : '0;
            acc_pop = acc << OUT_WIDTH;
        end
        acc_nxt = acc_pop;
        cnt_nxt = cnt_pop;
        if (state == EMIT && can_take) begin
            acc_nxt = acc_pop | (tok_top >> cnt_pop);
            cnt_nxt = cnt_pop + tok_len;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FILL;
            FILL:       if (la_count == LA_C || (last_seen && la_count != '0))
                            state_nxt = (hist_count == '0) ? EMIT : SEARCH;
            SEARCH:     if (cand_end && d == max_d) state_nxt = EMIT;
            EMIT:       if (can_take) state_nxt = COMMIT;
            COMMIT:     if (commit_left == LENGTH_BITS'(1))
                            state_nxt = !last_seen ? FILL : ((la_count != LENGTH_BITS'(1)) ? SEARCH : FLUSH);
            FLUSH:      if (acc_cnt == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);
    assign io.s_ready = (state == FILL) && (la_count != LA_C) && !last_seen;
    assign accept     = io.s_valid && io.s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            hist_count  <= '0;
            la_count    <= '0;
            last_seen   <= 1'b0;
            tail        <= 1'b0;
            acc         <= '0;
            acc_cnt     <= '0;
            d           <= OFFSET_BITS'(1);
            k           <= '0;
            best_len    <= '0;
            best_dist   <= '0;
            commit_left <= '0;
            bytes_in    <= '0;
            tokens_out  <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            acc_cnt <= cnt_nxt;
            case (state)
                IDLE, DONE: if (start) begin
                    wr_ptr     <= '0;
                    hist_count <= '0;
                    la_count   <= '0;
                    last_seen  <= 1'b0;
                    tail       <= 1'b0;
                    d          <= OFFSET_BITS'(1);
                    k          <= '0;
                    best_len   <= '0;
                    bytes_in   <= '0;
                    tokens_out <= '0;
                end
                FILL: if (accept) begin
                    la_count  <= la_count + 1'b1;
                    last_seen <= io.s_last;
                    bytes_in  <= bytes_in + 32'd1;
                end
                SEARCH: begin
                    if (cand_end) begin
                        if (cand_len > best_len) begin
                            best_len  <= cand_len;
                            best_dist <= d;
                        end
                        if (d != max_d) d <= d + 1'b1;
                        k <= '0;
                    end else begin
                        k <= k_inc;
                    end
                end
                EMIT: if (can_take) begin
                    commit_left <= consume;
                    tokens_out  <= tokens_out + 32'd1;
                    tail        <= last_seen && (consume == la_count);
                    d           <= OFFSET_BITS'(1);
                    k           <= '0;
                    best_len    <= '0;
                end
                COMMIT: begin
                    wr_ptr      <= (wr_ptr == HIST_LAST) ? '0 : wr_ptr + 1'b1;
                    hist_count  <= (hist_count == HIST_C) ? hist_count : hist_count + 1'b1;
                    la_count    <= la_count - 1'b1;
                    commit_left <= commit_left - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Byte storage needs no reset: hist_count and la_count define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (state == COMMIT) begin
            hist[wr_ptr] <= la[0];
            for (int i = 0; i < LA_DEPTH - 1; i++) la[i] <= la[i+1];
        end else if (accept) begin
            la[la_count] <= io.s_data;
        end
    end
endmodule

// File: tb/tb_lz77_stream_compressor.sv
// tb/tb_lz77_stream_compressor.sv - directed bench for lz77_stream_compressor (default and SEARCH_DEPTH=4 instances)
module tb_lz77_stream_compressor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_d = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  s_data_d = 8'h00;
    logic        s_valid_d = 1'b0;
    logic        s_last_d = 1'b0;
    logic        m_ready_d = 1'b1;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] bi_a, to_a, bi_b, to_b;

    lz77_stream_compressor_if #(.OUT_WIDTH(8)) ifa ();
    lz77_stream_compressor_if #(.OUT_WIDTH(8)) ifb ();

    assign ifa.s_data  = s_data_d;
    assign ifa.s_valid = s_valid_d & ~sel;
    assign ifa.s_last  = s_last_d;
    assign ifa.m_ready = m_ready_d;
    assign ifb.s_data  = s_data_d;
    assign ifb.s_valid = s_valid_d & sel;
    assign ifb.s_last  = s_last_d;
    assign ifb.m_ready = m_ready_d;

    lz77_stream_compressor dut (
        .clk(clk), .rst(rst), .start(start_d & ~sel), .busy(busy_a), .done(done_a),
        .bytes_in(bi_a), .tokens_out(to_a), .io(ifa.slave)
    );

    lz77_stream_compressor #(.SEARCH_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_d & sel), .busy(busy_b), .done(done_b),
        .bytes_in(bi_b), .tokens_out(to_b), .io(ifb.slave)
    );

    wire        cur_busy    = sel ? busy_b : busy_a;
    wire        cur_done    = sel ? done_b : done_a;
    wire [31:0] cur_bytes   = sel ? bi_b : bi_a;
    wire [31:0] cur_tokens  = sel ? to_b : to_a;
    wire        cur_s_ready = sel ? ifb.s_ready : ifa.s_ready;
    wire        cur_m_valid = sel ? ifb.m_valid : ifa.m_valid;
    wire        cur_m_last  = sel ? ifb.m_last : ifa.m_last;
    wire [7:0]  cur_m_data  = sel ? ifb.m_data : ifa.m_data;

    int         total = 0;
    int         bad = 0;
    logic [7:0] stim [0:127];
    logic [7:0] got_w [$];
    logic       got_l [$];
    logic [7:0] exp_w [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_stream(input string tag, input logic s, input int n, input int stall_len);
        int         i, cyc, stall;
        logic       held_v, held_last, ok_end;
        logic [7:0] held;
        sel = s;
        got_w.delete();
        got_l.delete();
        @(posedge clk); #1;
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        i = 0; cyc = 0; stall = 0; held_v = 1'b0; held_last = 1'b0; held = 8'h00; ok_end = 1'b0;
        while (cyc < 5000) begin
            if (cur_done) begin
                ok_end = 1'b1;
                break;
            end
            s_valid_d = (i < n);
            s_data_d  = stim[(i < n) ? i : 0];
            s_last_d  = (i == n - 1);
            m_ready_d = !(stall_len > 0 && got_w.size() >= 2 && stall < stall_len);
            if (!m_ready_d) begin
                stall++;
                if (cur_m_valid) begin
                    if (held_v) begin
                        chk({tag, "_stall_data"}, 32'(cur_m_data), 32'(held));
                        chk({tag, "_stall_last"}, 32'(cur_m_last), 32'(held_last));
                    end else begin
                        held      = cur_m_data;
                        held_last = cur_m_last;
                        held_v    = 1'b1;
                    end
                end
            end
            if (s_valid_d && cur_s_ready) i++;
            if (m_ready_d && cur_m_valid) begin
                got_w.push_back(cur_m_data);
                got_l.push_back(cur_m_last);
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid_d = 1'b0;
        s_last_d  = 1'b0;
        m_ready_d = 1'b1;
        chk({tag, "_finished"}, 32'(ok_end), 32'd1);
        if (stall_len > 0) chk({tag, "_stall_seen"}, 32'(held_v), 32'd1);
    endtask

    task automatic check_out(input string tag, input int nb, input int nt);
        int n;
        chk({tag, "_nwords"}, 32'(got_w.size()), 32'(exp_w.size()));
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s_word%0d", tag, j), 32'(got_w[j]), 32'(exp_w[j]));
            chk($sformatf("%s_last%0d", tag, j), 32'(got_l[j]), 32'(j == exp_w.size() - 1));
        end
        chk({tag, "_bytes_in"}, cur_bytes, 32'(nb));
        chk({tag, "_tokens_out"}, cur_tokens, 32'(nt));
        chk({tag, "_done"}, 32'(cur_done), 32'd1);
        chk({tag, "_busy"}, 32'(cur_busy), 32'd0);
    endtask

    initial begin
        int i, cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_m_valid", 32'(ifa.m_valid), 32'd0);
        chk("rst_s_ready", 32'(ifa.s_ready), 32'd0);
        chk("rst_bytes_in", bi_a, 32'd0);
        chk("rst_tokens_out", to_a, 32'd0);
        rst = 1'b0;

        stim[0] = 8'h41;
        exp_w = '{8'hA0, 8'h80};
        run_stream("t1", 1'b0, 1, 0);
        check_out("t1", 1, 1);

        for (int j = 0; j < 9; j++) stim[j] = 8'(8'h41 + j % 3);
        exp_w = '{8'hA0, 8'hD0, 8'hA8, 8'h60, 8'h03, 8'h18};
        run_stream("t2", 1'b0, 9, 0);
        check_out("t2", 9, 4);

        for (int j = 0; j < 70; j++) stim[j] = 8'h00;
        exp_w = '{8'h80, 8'h00, 8'h07, 8'hF0, 8'h00, 8'h8C};
        run_stream("t3", 1'b0, 70, 0);
        check_out("t3", 70, 3);

        for (int j = 0; j < 9; j++) stim[j] = 8'(8'h41 + j % 3);
        exp_w = '{8'hA0, 8'hD0, 8'hA8, 8'h60, 8'h03, 8'h18};
        run_stream("t4", 1'b0, 9, 10);
        check_out("t4", 9, 4);

        for (int j = 0; j < 10; j++) stim[j] = 8'(8'h41 + j % 5);
        exp_w = '{8'hA0, 8'hD0, 8'hA8, 8'h74, 8'h4A, 8'h2D,
                  8'h06, 8'h85, 8'h43, 8'hA2, 8'h51, 8'h40};
        run_stream("t5", 1'b1, 10, 0);
        check_out("t5", 10, 10);

        sel = 1'b0;
        for (int j = 0; j < 9; j++) stim[j] = 8'(8'h41 + j % 3);
        @(posedge clk); #1;
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        i = 0; cyc = 0;
        while (!ifa.m_valid && cyc < 500) begin
            s_valid_d = (i < 9);
            s_data_d  = stim[(i < 9) ? i : 0];
            s_last_d  = (i == 8);
            if (s_valid_d && ifa.s_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_first_word", 32'(ifa.m_valid), 32'd1);
        s_valid_d = 1'b0;
        s_last_d  = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy_before_rst", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_busy", 32'(busy_a), 32'd0);
        chk("t6_m_valid", 32'(ifa.m_valid), 32'd0);
        chk("t6_s_ready", 32'(ifa.s_ready), 32'd0);
        chk("t6_done", 32'(done_a), 32'd0);
        chk("t6_tokens_out", to_a, 32'd0);

        stim[0] = 8'h41;
        exp_w = '{8'hA0, 8'h80};
        run_stream("t6r", 1'b0, 1, 0);
        check_out("t6r", 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
